// File: rtl/butterfly.sv
// Pipelined modular butterfly for the NTT/INTT datapath.
// Cooley-Tukey or Gentleman-Sande over q = 8380417 or q = 3329, selected per operation.
// Four register levels: input capture, reduction/GS add-sub, multiply, product reduction/CT add-sub.
module butterfly (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [23:0] a_i,
    input  logic [23:0] b_i,
    input  logic [22:0] twiddle_i,
    input  logic        sel_red_i,
    input  logic        sel_butterfly_i,
    output logic [22:0] a_o,
    output logic [22:0] b_o
);

    typedef enum logic {
        MOD_D = 1'b0,
        MOD_K = 1'b1
    } modulus_e;

    typedef enum logic {
        MODE_CT = 1'b0,
        MODE_GS = 1'b1
    } mode_e;

    // Raw operands as sampled from the ports.
    typedef struct packed {
        modulus_e    modulus;
        mode_e       mode;
        logic [23:0] a;
        logic [23:0] b;
        logic [22:0] tw;
    } in_t;

    // Canonical operands ready for the multiplier.
    // pass: value that bypasses the multiplier (A for CT, A+B for GS).
    // mul:  multiplicand (B for CT, A-B for GS).
    typedef struct packed {
        modulus_e    modulus;
        mode_e       mode;
        logic [22:0] pass;
        logic [22:0] mul;
        logic [22:0] tw;
    } s1_t;

    // Raw 46-bit product plus the bypass value.
    typedef struct packed {
        modulus_e    modulus;
        mode_e       mode;
        logic [22:0] pass;
        logic [45:0] prod;
    } s2_t;

    localparam logic [23:0] Q_D  = 24'd8380417;
    localparam logic [23:0] Q_D2 = 24'd16760834;
    localparam logic [23:0] Q_K  = 24'd3329;

    // Barrett constants: floor(2^k / q), k = 46 for the Dilithium product,
    // k = 36 for any 24-bit value mod 3329 (covers Kyber inputs and products).
    localparam logic [23:0] M_D = 24'((64'd1 << 46) / 64'd8380417);
    localparam logic [24:0] M_K = 25'((64'd1 << 36) / 64'd3329);

    function automatic logic [23:0] modulus_value(input modulus_e m);
        return (m == MOD_K) ? Q_K : Q_D;
    endfunction

    // Any 24-bit value mod 3329. The Barrett quotient is at most one short,
    // so a single conditional subtraction makes the result canonical.
    function automatic logic [22:0] red_k24(input logic [23:0] x);
        logic [48:0] prod;
        logic [23:0] qt;
        logic [23:0] r;
        prod = {25'd0, x} * {24'd0, M_K};
        qt   = 24'(prod >> 36);
        r    = x - qt * Q_K;
        if (r >= Q_K) begin
            r = r - Q_K;
        end
        return 23'(r);
    endfunction

    // Any 24-bit value mod 8380417: 2^24 < 3q, so at most two subtractions.
    function automatic logic [22:0] red_d24(input logic [23:0] x);
        logic [23:0] r;
        r = x;
        if (r >= Q_D2) begin
            r = r - Q_D2;
        end else if (r >= Q_D) begin
            r = r - Q_D;
        end
        return 23'(r);
    endfunction

    // Product of two canonical Dilithium values (< q^2 < 2^46) mod 8380417.
    function automatic logic [22:0] red_d46(input logic [45:0] p);
        logic [69:0] prod;
        logic [23:0] qt;
        logic [45:0] r;
        prod = {24'd0, p} * {46'd0, M_D};
        qt   = 24'(prod >> 46);
        r    = p - {22'd0, qt} * {22'd0, Q_D};
        if (r >= {22'd0, Q_D}) begin
            r = r - {22'd0, Q_D};
        end
        return 23'(r);
    endfunction

    function automatic logic [22:0] reduce_in(input logic [23:0] x, input modulus_e m);
        return (m == MOD_K) ? red_k24(x) : red_d24(x);
    endfunction

    // Kyber products are below 3329^2 < 2^24, so the 24-bit reducer suffices.
    function automatic logic [22:0] reduce_prod(input logic [45:0] p, input modulus_e m);
        return (m == MOD_K) ? red_k24(p[23:0]) : red_d46(p);
    endfunction

    function automatic logic [22:0] add_mod(input logic [22:0] x, input logic [22:0] y,
                                            input logic [23:0] q);
        logic [23:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= q) begin
            s = s - q;
        end
        return 23'(s);
    endfunction

    // Wraps mod 2^24 when x < y; adding q brings it back into [0, q).
    function automatic logic [22:0] sub_mod(input logic [22:0] x, input logic [22:0] y,
                                            input logic [23:0] q);
        logic [23:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (x < y) begin
            d = d + q;
        end
        return 23'(d);
    endfunction

    in_t         in_q;
    s1_t         s1_q;
    s1_t         s1_next;
    s2_t         s2_q;
    logic [22:0] red_a;
    logic [22:0] red_b;
    logic [22:0] red_w;
    logic [23:0] q1;
    logic [22:0] t3;
    logic [23:0] q3;
    logic [22:0] a_next;
    logic [22:0] b_next;

    // Capture the raw operands and selectors together so mode travels with data.
    always_ff @(posedge clk_i) begin
        // NOTE: every register in this design uses non-blocking assignment so all
        // stages update from pre-edge values and the pipeline shifts cleanly.
        if (rst_i) begin
            in_q <= '0;
        end else begin
            in_q.modulus <= modulus_e'(sel_red_i);
            in_q.mode    <= mode_e'(sel_butterfly_i);
            in_q.a       <= a_i;
            in_q.b       <= b_i;
            in_q.tw      <= twiddle_i;
        end
    end

    // Reduce operands to canonical form and do the GS add/sub ahead of the multiplier.
    always_comb begin
        red_a           = reduce_in(in_q.a, in_q.modulus);
        red_b           = reduce_in(in_q.b, in_q.modulus);
        red_w           = reduce_in({1'b0, in_q.tw}, in_q.modulus);
        q1              = modulus_value(in_q.modulus);
        s1_next.modulus = in_q.modulus;
        s1_next.mode    = in_q.mode;
        s1_next.tw      = red_w;
        s1_next.pass    = red_a;
        s1_next.mul     = red_b;
        if (in_q.mode == MODE_GS) begin
            s1_next.pass = add_mod(red_a, red_b, q1);
            s1_next.mul  = sub_mod(red_a, red_b, q1);
        end
    end

    // Register the canonical operands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= '0;
        end else begin
            s1_q <= s1_next;
        end
    end

    // Full-width multiply of the selected operand by the twiddle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_q <= '0;
        end else begin
            s2_q.modulus <= s1_q.modulus;
            s2_q.mode    <= s1_q.mode;
            s2_q.pass    <= s1_q.pass;
            s2_q.prod    <= {23'd0, s1_q.mul} * {23'd0, s1_q.tw};
        end
    end

    // Reduce the product, then the CT add/sub; GS results pass straight through.
    always_comb begin
        t3     = reduce_prod(s2_q.prod, s2_q.modulus);
        q3     = modulus_value(s2_q.modulus);
        a_next = s2_q.pass;
        b_next = t3;
        if (s2_q.mode == MODE_CT) begin
            a_next = add_mod(s2_q.pass, t3, q3);
            b_next = sub_mod(s2_q.pass, t3, q3);
        end
    end

    // Output registers; reset clears them so discarded work never appears.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_o <= '0;
            b_o <= '0;
        end else begin
            a_o <= a_next;
            b_o <= b_next;
        end
    end

endmodule

// File: tb/tb_butterfly.sv
// Self-checking bench for butterfly: directed vectors with literal results,
// back-to-back streaming, mid-stream reset and a randomized run against a
// plain-arithmetic model of the modular butterfly.
module tb_butterfly;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] a   = '0;
    logic [23:0] b   = '0;
    logic [22:0] w   = '0;
    logic        red = 1'b0;
    logic        bf  = 1'b0;
    logic [22:0] a_o;
    logic [22:0] b_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic   rst;
        longint a;
        longint b;
        longint w;
        logic   red;
        logic   bf;
    } op_t;

    localparam int MAX_EDGES = 4096;
    op_t rec[MAX_EDGES];
    int  n_edges = 0;

    always #5 clk = ~clk;

    butterfly dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .a_i            (a),
        .b_i            (b),
        .twiddle_i      (w),
        .sel_red_i      (red),
        .sel_butterfly_i(bf),
        .a_o            (a_o),
        .b_o            (b_o)
    );

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Butterfly straight from the arithmetic definition.
    function automatic void model(input longint va, input longint vb, input longint vw,
                                  input logic vred, input logic vbf,
                                  output longint ea, output longint eb);
        longint q, ra, rb, rw, t;
        q  = vred ? 64'd3329 : 64'd8380417;
        ra = va % q;
        rb = vb % q;
        rw = vw % q;
        if (!vbf) begin
            t  = (rb * rw) % q;
            ea = (ra + t) % q;
            eb = (ra - t + q) % q;
        end else begin
            ea = (ra + rb) % q;
            eb = (((ra - rb + q) % q) * rw) % q;
        end
    endfunction

    // Log what the DUT samples on every edge.
    always @(posedge clk) begin
        if (n_edges < MAX_EDGES) begin
            rec[n_edges] <= '{rst, longint'(a), longint'(b), longint'(w), red, bf};
            n_edges      <= n_edges + 1;
        end
    end

    // Output after edge n: zero if reset was seen on edges n-3..n, else the op sampled at n-3.
    always @(negedge clk) begin : compare
        int     idx;
        logic   any_rst;
        longint ea, eb;
        idx = n_edges - 1;
        if (idx >= 0) begin
            any_rst = 1'b0;
            for (int k = idx - 3; k <= idx; k++) begin
                if (k >= 0 && rec[k].rst) any_rst = 1'b1;
            end
            if (any_rst) begin
                check("reset_a", longint'(a_o), 0);
                check("reset_b", longint'(b_o), 0);
            end else if (idx >= 3) begin
                model(rec[idx-3].a, rec[idx-3].b, rec[idx-3].w,
                      rec[idx-3].red, rec[idx-3].bf, ea, eb);
                check("pipe_a", longint'(a_o), ea);
                check("pipe_b", longint'(b_o), eb);
                if (rec[idx-3].red) begin
                    check("kyber_high_bits", longint'({a_o[22:12], b_o[22:12]}), 0);
                end
            end
        end
    end

    task automatic drive(input longint va, input longint vb, input longint vw,
                         input logic vred, input logic vbf);
        a   = 24'(va);
        b   = 24'(vb);
        w   = 23'(vw);
        red = vred;
        bf  = vbf;
    endtask

    function automatic longint pick24(input longint q);
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 24'hFFFFFF;
            2:       return q - 1;
            3:       return q;
            4:       return 2 * q - 1;
            default: return longint'($urandom_range(0, 24'hFFFFFF));
        endcase
    endfunction

    // Directed vectors with hand-computed results.
    localparam int NV = 7;
    longint v_a  [NV] = '{1, 5, 3, 8380417, 16777215, 3328, 0};
    longint v_b  [NV] = '{2, 3, 5, 0,       0,        1,    1};
    longint v_w  [NV] = '{3, 10, 1, 0,      0,        1,    4000};
    logic   v_red[NV] = '{0, 0, 0, 0,       0,        1,    1};
    logic   v_bf [NV] = '{0, 1, 1, 0,       0,        0,    1};
    longint v_ea [NV] = '{7, 8, 8, 0,       16381,    0,    1};
    longint v_eb [NV] = '{8380412, 20, 8380415, 0, 16381, 3327, 2658};

    initial begin : stimulus
        longint ea, eb, q;

        // Pin the reference model against hand-computed results.
        model(1, 2, 3, 0, 0, ea, eb);
        check("model_ct_d_b", eb, 8380412);
        model(3, 5, 1, 0, 1, ea, eb);
        check("model_gs_d_b", eb, 8380415);
        model(0, 1, 4000, 1, 1, ea, eb);
        check("model_gs_k_b", eb, 2658);

        repeat (4) @(negedge clk);
        rst = 1'b0;

        // Isolated operations: result after the fourth edge counted from the sampling edge.
        for (int i = 0; i < NV; i++) begin
            drive(v_a[i], v_b[i], v_w[i], v_red[i], v_bf[i]);
            repeat (4) @(posedge clk);
            #1;
            check($sformatf("single%0d_a", i), longint'(a_o), v_ea[i]);
            check($sformatf("single%0d_b", i), longint'(b_o), v_eb[i]);
            @(negedge clk);
        end

        // Back-to-back streaming: each result exactly three edges behind its inputs.
        for (int i = 0; i < NV + 3; i++) begin
            if (i < NV) drive(v_a[i], v_b[i], v_w[i], v_red[i], v_bf[i]);
            else        drive(0, 0, 0, 0, 0);
            @(posedge clk);
            #1;
            if (i >= 3) begin
                check($sformatf("stream%0d_a", i - 3), longint'(a_o), v_ea[i-3]);
                check($sformatf("stream%0d_b", i - 3), longint'(b_o), v_eb[i-3]);
            end
            @(negedge clk);
        end

        // Mid-stream reset with three operations in flight.
        for (int i = 1; i <= 3; i++) begin
            drive(v_a[i], v_b[i], v_w[i], v_red[i], v_bf[i]);
            @(negedge clk);
        end
        rst = 1'b1;
        drive(v_a[4], v_b[4], v_w[4], v_red[4], v_bf[4]);
        @(posedge clk);
        #1;
        check("midrst_edge_a", longint'(a_o), 0);
        check("midrst_edge_b", longint'(b_o), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(v_a[0], v_b[0], v_w[0], v_red[0], v_bf[0]);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (i < 4) begin
                check($sformatf("midrst_flush%0d", i), longint'({a_o, b_o}), 0);
            end else begin
                check("midrst_next_a", longint'(a_o), v_ea[0]);
                check("midrst_next_b", longint'(b_o), v_eb[0]);
            end
        end
        @(negedge clk);

        // Randomized run with corner-biased operands and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            logic r_red;
            r_red = logic'($urandom_range(0, 1));
            q     = r_red ? 64'd3329 : 64'd8380417;
            rst   = ($urandom_range(0, 99) == 0);
            drive(pick24(q), pick24(q), pick24(q) & 64'h7FFFFF, r_red,
                  logic'($urandom_range(0, 1)));
            @(negedge clk);
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (6) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
